// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, done / framing-error pulses
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic       uart_rx_done,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_busy
);

    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int          BAUD_CNT_MID = BAUD_CNT_MAX / 2;
    localparam logic [15:0] CNT_LAST     = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] CNT_MID      = 16'(BAUD_CNT_MID);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    logic        rxd_s1;
    logic        rxd_s2;
    logic        rxd_s3;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        start_edge;
    logic        sample;
    logic        wrap;
    logic [2:0]  data_idx;

    assign start_edge = rxd_s3 & ~rxd_s2;
    assign sample     = (state != IDLE) && (baud_cnt == CNT_MID);
    assign wrap       = (baud_cnt == CNT_LAST);
    // bit_cnt 1..8 maps to shift-register bit 0..7
    assign data_idx   = bit_cnt[2:0] - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            baud_cnt          <= 16'd0;
            bit_cnt           <= 4'd0;
            shift_reg         <= 8'h00;
            uart_rx_done      <= 1'b0;
            uart_rx_data      <= 8'h00;
            uart_rx_frame_err <= 1'b0;
            uart_rx_busy      <= 1'b0;
        end else begin
            uart_rx_done      <= 1'b0;
            uart_rx_frame_err <= 1'b0;

            if (state == IDLE) begin
                baud_cnt <= 16'd0;
                bit_cnt  <= 4'd0;
            end else if (wrap) begin
                baud_cnt <= 16'd0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end

            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        state        <= START;
                        uart_rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (sample && rxd_s2) begin
                        state        <= IDLE;
                        uart_rx_busy <= 1'b0;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg[data_idx] <= rxd_s2;
                    end
                    if (wrap && (bit_cnt == 4'd8)) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so an immediately following start edge is caught
                    if (sample) begin
                        state        <= IDLE;
                        uart_rx_busy <= 1'b0;
                        if (rxd_s2) begin
                            uart_rx_data <= shift_reg;
                            uart_rx_done <= 1'b1;
                        end else begin
                            uart_rx_frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : self-checking bench for uart_rx against a frame-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BIT_P   = 434;
    localparam int MID     = 217;
    localparam int LATENCY = 4127;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_done;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [7:0] got_data[$];
    int         got_cyc[$];
    int         err_cyc[$];
    int         both_cnt = 0;
    int         busy_rises = 0;
    logic       busy_d = 1'b0;
    logic [7:0] last_good = 8'h00;

    uart_rx dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_rxd          (uart_rxd),
        .uart_rx_done      (uart_rx_done),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_busy      (uart_rx_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_rx_done) begin
            got_data.push_back(uart_rx_data);
            got_cyc.push_back(cyc);
        end
        if (uart_rx_frame_err) err_cyc.push_back(cyc);
        if (uart_rx_done && uart_rx_frame_err) both_cnt++;
        if (uart_rx_busy && !busy_d) busy_rises++;
        busy_d = uart_rx_busy;
    end

    // All line-driving tasks start and end 1 time unit after a rising clock edge
    task automatic drive_bit(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv, input int per,
                              output int c0);
        c0 = cyc;
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stopv, per);
    endtask

    task automatic clear_obs();
        got_data.delete();
        got_cyc.delete();
        err_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uart_rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if ({uart_rx_done, uart_rx_frame_err, uart_rx_busy, uart_rx_data} !== 11'h000) begin
            mismatched++;
            $display("FAIL reset_values: got done=%b err=%b busy=%b data=%h, want 0 0 0 00",
                     uart_rx_done, uart_rx_frame_err, uart_rx_busy, uart_rx_data);
        end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_single_byte();
        int c0;
        clear_obs();
        send_frame(8'h55, 1'b1, BIT_P, c0);
        idle(20);
        compared++;
        if (got_data.size() != 1 || err_cyc.size() != 0) begin
            mismatched++;
            $display("FAIL single_count: got %0d done %0d err, want 1 done 0 err",
                     got_data.size(), err_cyc.size());
        end else begin
            compared++;
            if (got_data[0] !== 8'h55) begin
                mismatched++;
                $display("FAIL single_data: got %h want 55", got_data[0]);
            end
            compared++;
            if (got_cyc[0] - c0 < LATENCY - 2 || got_cyc[0] - c0 > LATENCY + 2) begin
                mismatched++;
                $display("FAIL single_latency: got %0d want %0d+-2", got_cyc[0] - c0, LATENCY);
            end
        end
        last_good = 8'h55;
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        int low_run = -1;
        clear_obs();
        fork
            begin
                send_frame(8'hA3, 1'b1, BIT_P, c0);
                send_frame(8'h0F, 1'b1, BIT_P, c1);
            end
            begin
                int k;
                k = 0;
                while (!uart_rx_done && k < 6000) begin @(negedge clk); k++; end
                if (k < 6000) begin
                    low_run = 0;
                    while (!uart_rx_busy && low_run < 2000) begin @(negedge clk); low_run++; end
                end
            end
        join
        idle(20);
        compared++;
        if (got_data.size() != 2 || err_cyc.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d done %0d err, want 2 done 0 err",
                     got_data.size(), err_cyc.size());
        end else begin
            compared++;
            if (got_data[0] !== 8'hA3 || got_data[1] !== 8'h0F) begin
                mismatched++;
                $display("FAIL b2b_data: got %h %h want a3 0f", got_data[0], got_data[1]);
            end
        end
        compared++;
        if (low_run < 0 || low_run > BIT_P) begin
            mismatched++;
            $display("FAIL b2b_busy_gap: got %0d cycles low, want <= %0d", low_run, BIT_P);
        end
        last_good = 8'h0F;
    endtask

    task automatic test_false_start();
        int c0;
        int fall = -1;
        clear_obs();
        c0 = cyc;
        drive_bit(1'b0, 100);
        uart_rxd = 1'b1;
        compared++;
        if (uart_rx_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL false_busy_high: got %b want 1", uart_rx_busy);
        end
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!uart_rx_busy && fall < 0) fall = cyc;
        end
        @(posedge clk);
        #1;
        compared++;
        if (fall < 0 || fall - c0 > MID + 5) begin
            mismatched++;
            $display("FAIL false_busy_fall: got %0d cycles want <= %0d", fall - c0, MID + 5);
        end
        compared++;
        if (got_data.size() != 0 || err_cyc.size() != 0) begin
            mismatched++;
            $display("FAIL false_pulses: got %0d done %0d err, want 0 0",
                     got_data.size(), err_cyc.size());
        end
    endtask

    task automatic test_framing_error();
        int c0;
        int c1;
        int rises;
        clear_obs();
        send_frame(8'h3C, 1'b1, BIT_P, c0);
        idle(30);
        send_frame(8'h7E, 1'b0, BIT_P, c1);
        rises = busy_rises;
        drive_bit(1'b0, 2 * BIT_P);
        compared++;
        if (err_cyc.size() != 1 || got_data.size() != 1) begin
            mismatched++;
            $display("FAIL ferr_count: got %0d err %0d done, want 1 err 1 done",
                     err_cyc.size(), got_data.size());
        end else begin
            compared++;
            if (err_cyc[0] - c1 < LATENCY - 2 || err_cyc[0] - c1 > LATENCY + 2) begin
                mismatched++;
                $display("FAIL ferr_latency: got %0d want %0d+-2", err_cyc[0] - c1, LATENCY);
            end
        end
        compared++;
        if (uart_rx_data !== 8'h3C) begin
            mismatched++;
            $display("FAIL ferr_data_held: got %h want 3c", uart_rx_data);
        end
        compared++;
        if (busy_rises != rises || uart_rx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ferr_break_quiet: got %0d busy rises busy=%b, want 0 rises busy=0",
                     busy_rises - rises, uart_rx_busy);
        end
        idle(100);
        send_frame(8'h81, 1'b1, BIT_P, c0);
        idle(20);
        compared++;
        if (got_data.size() != 2 || err_cyc.size() != 1) begin
            mismatched++;
            $display("FAIL ferr_recover_count: got %0d done %0d err, want 2 1",
                     got_data.size(), err_cyc.size());
        end else begin
            compared++;
            if (got_data[1] !== 8'h81) begin
                mismatched++;
                $display("FAIL ferr_recover_data: got %h want 81", got_data[1]);
            end
        end
        last_good = 8'h81;
    endtask

    task automatic test_baud_skew();
        int c0;
        logic [7:0] bytes [2];
        int pers [2];
        bytes[0] = 8'hFF; pers[0] = 451;
        bytes[1] = 8'h00; pers[1] = 416;
        for (int i = 0; i < 2; i++) begin
            clear_obs();
            send_frame(bytes[i], 1'b1, pers[i], c0);
            idle(20);
            compared++;
            if (got_data.size() != 1 || err_cyc.size() != 0) begin
                mismatched++;
                $display("FAIL skew_count_%0d: got %0d done %0d err, want 1 0",
                         pers[i], got_data.size(), err_cyc.size());
            end else begin
                compared++;
                if (got_data[0] !== bytes[i]) begin
                    mismatched++;
                    $display("FAIL skew_data_%0d: got %h want %h", pers[i], got_data[0], bytes[i]);
                end
            end
            last_good = bytes[i];
        end
    endtask

    task automatic test_random();
        int c0;
        logic [7:0] b;
        logic stopv;
        for (int n = 0; n < 3; n++) begin
            clear_obs();
            b = 8'($urandom);
            stopv = ($urandom_range(0, 3) != 0);
            send_frame(b, stopv, BIT_P, c0);
            idle(10 + $urandom_range(0, 40));
            if (stopv) last_good = b;
            compared++;
            if (got_data.size() != (stopv ? 1 : 0) || err_cyc.size() != (stopv ? 0 : 1)) begin
                mismatched++;
                $display("FAIL rand_count_%0d: got %0d done %0d err, stop=%b",
                         n, got_data.size(), err_cyc.size(), stopv);
            end
            compared++;
            if (uart_rx_data !== last_good) begin
                mismatched++;
                $display("FAIL rand_data_%0d: got %h want %h", n, uart_rx_data, last_good);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        logic [7:0] b;
        b = 8'h5A;
        clear_obs();
        drive_bit(1'b0, BIT_P);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_P);
        drive_bit(b[4], BIT_P / 2);
        rst_n = 1'b0;
        uart_rxd = 1'b1;
        #1;
        compared++;
        if ({uart_rx_done, uart_rx_frame_err, uart_rx_busy, uart_rx_data} !== 11'h000) begin
            mismatched++;
            $display("FAIL midrst_values: got done=%b err=%b busy=%b data=%h, want 0 0 0 00",
                     uart_rx_done, uart_rx_frame_err, uart_rx_busy, uart_rx_data);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2 * BIT_P);
        last_good = 8'h00;
        compared++;
        if (got_data.size() != 0 || err_cyc.size() != 0 || uart_rx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_quiet: got %0d done %0d err busy=%b, want 0 0 0",
                     got_data.size(), err_cyc.size(), uart_rx_busy);
        end
        send_frame(8'hC6, 1'b1, BIT_P, c0);
        idle(20);
        compared++;
        if (got_data.size() != 1 || got_data[0] !== 8'hC6) begin
            mismatched++;
            $display("FAIL midrst_recover: got %0d done data=%h, want 1 done c6",
                     got_data.size(), uart_rx_data);
        end
    endtask

    task automatic test_exclusive();
        compared++;
        if (both_cnt != 0) begin
            mismatched++;
            $display("FAIL done_err_overlap: got %0d cycles with both high, want 0", both_cnt);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_false_start();
        test_framing_error();
        test_baud_skew();
        test_random();
        test_reset_mid_frame();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART serial receiver for 8N1 frames, the receive-side counterpart of the team's UART transmitter. It synchronises the asynchronous `uart_rxd` line into `clk`, detects the start bit, samples each bit at its midpoint and delivers the byte with a one-cycle valid pulse. It sits between the board RX pin and the user logic, usually a loopback path into the transmitter or a command parser. Framing errors and false starts are flagged or discarded; no byte is delivered for them.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `BAUD_CNT_MAX`: localparam = CLK_FREQ/UART_BPS (integer divide; 434 at defaults). It is the number of clocks per bit.
- `BAUD_CNT_MID`: localparam = BAUD_CNT_MAX/2 (217 at defaults). It is the sample point within a bit.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low. Clock is `clk`.
- `uart_rxd`  in  1  serial input, asynchronous to `clk`, idle high.
- `uart_rx_done`  out  1  one-cycle pulse: `uart_rx_data` holds a newly received, correctly framed byte.
- `uart_rx_data`  out  8  last good byte. Updated only in the cycle `uart_rx_done` asserts, and held otherwise.
- `uart_rx_frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `uart_rx_busy`  out  1  high while a frame is being received (FSM not IDLE).

## Operation
- **Synchroniser:** a 3-stage shift register, `rxd_s1 <= uart_rxd`, `rxd_s2 <= rxd_s1`, `rxd_s3 <= rxd_s2`. All decisions use `rxd_s2`. Start edge = `rxd_s3 & ~rxd_s2`. Reset value of all three stages is 1.
- **Counters:**
  - `baud_cnt` is 16 bits. It counts 0..BAUD_CNT_MAX-1, wraps to 0, and is held at 0 in IDLE.
  - `bit_cnt` is 4 bits, range 0..9. 0 = start bit, 1..8 = data LSB first, 9 = stop bit. It increments when `baud_cnt` wraps and is held at 0 in IDLE.
  - Sample strobe = (`baud_cnt` == BAUD_CNT_MID) while not IDLE.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE -> START on the start edge. `baud_cnt` and `bit_cnt` restart at 0.
  - START, at the sample strobe:
    - `rxd_s2` = 1: false start. Go to IDLE with no pulses.
    - `rxd_s2` = 0: stay in START until the `baud_cnt` wrap, then go to DATA.
  - DATA, at each sample strobe: shift `rxd_s2` into bit `bit_cnt`-1 of the shift register. After the wrap at `bit_cnt` = 8, go to STOP.
  - STOP, at the sample strobe (mid stop bit):
    - `rxd_s2` = 1: load `uart_rx_data` from the shift register and pulse `uart_rx_done`.
    - `rxd_s2` = 0: pulse `uart_rx_frame_err`; `uart_rx_data` is unchanged.
    - In both cases go to IDLE in the same cycle. The block does not wait out the second half of the stop bit, so a start edge arriving immediately after is caught.
- **Break / line stuck low:** after a framing error the FSM sits in IDLE. A new frame requires a fresh high-to-low edge, so no spurious frames occur while the line stays low.
- `uart_rx_done` and `uart_rx_frame_err` are never high in the same cycle.
- `uart_rxd` edges during START/DATA/STOP are ignored except at sample strobes. There is no resynchronisation on data-bit edges.

## Timing
- **Reset values:**
  - `uart_rx_done` = 0, `uart_rx_frame_err` = 0, `uart_rx_busy` = 0, `uart_rx_data` = 8'h00.
  - FSM = IDLE, counters = 0, shift register = 0.
- **Reset mid-frame:** the block returns to IDLE immediately. The partial byte is discarded and no pulse is issued.
- **Edge detect:** the start edge is recognised 3 clocks after the falling edge of `uart_rxd`, ±1 clock for metastability resolution.
- **Sample instants:** the sample for bit k (k = 0..9) occurs at start-edge-detect + k·BAUD_CNT_MAX + BAUD_CNT_MID clocks.
- **Output latency:**
  - `uart_rx_done` / `uart_rx_frame_err` assert one clock after the bit-9 sample instant (registered outputs).
  - At defaults this is about 9·434 + 217 + 4 ≈ 4127 clocks after the `uart_rxd` falling edge.
- **`uart_rx_busy`:** rises one clock after edge detect. It falls in the same cycle that the done/error pulse rises.
- **Tolerance:** total clock/baud mismatch up to ±4% over a frame must still be received correctly.

## Test plan
- **Single byte:** frame 0x55 at 115200 baud, default params. Expect exactly one `uart_rx_done` pulse, `uart_rx_data` = 0x55, `uart_rx_frame_err` never high, done at 4127±2 clocks after the start edge.
- **Back-to-back:** 0xA3 then 0x0F with zero idle between stop and next start. Expect two done pulses, data 0xA3 then 0x0F, `uart_rx_busy` low for ≤1 bit time between frames.
- **False start:** drive `uart_rxd` low for 100 clocks, then high. Expect no done, no frame_err, and `uart_rx_busy` back to 0 within BAUD_CNT_MID+5 clocks of the edge.
- **Framing error:** receive 0x3C, then send 0x7E with the stop bit driven low and held low for 3 bit times. Expect one `uart_rx_frame_err` pulse, no done, `uart_rx_data` remains 0x3C, and no further activity until the line goes high and a new frame of 0x81 arrives, which is received correctly.
- **Reset mid-frame:** assert `rst_n` low during bit 4 of a frame. Expect all outputs at reset values with no pulse. After release, a clean 0xC6 frame yields done with data 0xC6.
- **Baud skew:** send 0xFF and 0x00 with the bit period at 434·1.04 and then 434·0.96 clocks. Expect both bytes received correctly.
